// File: rtl/icache_if.sv
// Fetch-side and arbiter-side signals of the instruction cache, bundled.
// The cache uses the slave modport; the fetch stage and arbiter use master.
interface icache_if;
    logic        jal_reset;
    logic        nd_ins;
    logic [31:0] pc_fetch;
    logic        flg_get;
    logic [31:0] ins_in;
    logic        mem_req;
    logic [31:0] mem_a;
    logic        mem_gnt;
    logic [7:0]  mem_din;

    modport slave (
        input  jal_reset, nd_ins, pc_fetch, mem_gnt, mem_din,
        output flg_get, ins_in, mem_req, mem_a
    );

    modport master (
        output jal_reset, nd_ins, pc_fetch, mem_gnt, mem_din,
        input  flg_get, ins_in, mem_req, mem_a
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Misses are filled by
// four little-endian byte reads over the arbiter's 8-bit port.
module icache #(
    parameter int IDX_W = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);
    localparam int TAG_W = 30 - IDX_W;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_MISS, S_DONE} state_t;

    state_t            r_state;
    logic [29:0]       r_addr;
    logic [1:0]        r_k;
    logic [1:0]        r_cap;
    logic              r_pend;
    logic              r_mem_req;
    logic              r_flg;
    logic [31:0]       r_ins;
    logic [31:0]       r_mem_a;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag_mem  [LINES];
    logic [31:0]       r_data_mem [LINES];

    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic              w_grant;
    logic              w_cap_en;
    logic              w_fill;
    logic [23:0]       w_lanes;
    logic [31:0]       w_word;
    logic              w_unused_pc;

    assign w_idx       = bus.pc_fetch[IDX_W+1:2];
    assign w_tag       = bus.pc_fetch[31:IDX_W+2];
    assign w_fill_idx  = r_addr[IDX_W-1:0];
    assign w_hit       = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);
    assign w_grant     = bus.mem_gnt && r_mem_req;
    // r_pend marks that mem_din carries the byte granted on the previous edge
    assign w_cap_en    = rdy && !rst && !bus.jal_reset && (r_state == S_MISS) && r_pend;
    assign w_fill      = w_cap_en && (r_cap == 2'd3);
    assign w_word      = {bus.mem_din, w_lanes};
    assign w_unused_pc = ^bus.pc_fetch[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] r_byte;
            always_ff @(posedge clk) begin
                if (w_cap_en && (r_cap == 2'(gi))) begin
                    r_byte <= bus.mem_din;
                end
            end
            assign w_lanes[gi*8 +: 8] = r_byte;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag_mem[w_fill_idx]  <= r_addr[29:IDX_W];
            r_data_mem[w_fill_idx] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        r_flg <= 1'b0;
        if (rst) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            r_addr    <= '0;
            r_k       <= '0;
            r_cap     <= '0;
            r_pend    <= 1'b0;
            r_mem_req <= 1'b0;
            r_ins     <= '0;
            r_mem_a   <= '0;
        end else if (rdy) begin
            if (bus.jal_reset) begin
                r_state   <= S_IDLE;
                r_mem_req <= 1'b0;
                r_pend    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.nd_ins) begin
                            r_addr <= bus.pc_fetch[31:2];
                            r_k    <= '0;
                            r_cap  <= '0;
                            r_pend <= 1'b0;
                            if (w_hit) begin
                                r_ins   <= r_data_mem[w_idx];
                                r_flg   <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_mem_req <= 1'b1;
                                r_mem_a   <= {bus.pc_fetch[31:2], 2'b00};
                                r_state   <= S_MISS;
                            end
                        end
                    end
                    S_MISS: begin
                        r_pend <= w_grant;
                        if (w_grant) begin
                            r_k       <= r_k + 2'd1;
                            r_mem_a   <= {r_addr, r_k + 2'd1};
                            r_mem_req <= (r_k != 2'd3);
                        end
                        if (r_pend) begin
                            r_cap <= r_cap + 2'd1;
                            if (r_cap == 2'd3) begin
                                r_valid[w_fill_idx] <= 1'b1;
                                r_ins   <= w_word;
                                r_flg   <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.flg_get = r_flg;
    assign bus.ins_in  = r_ins;
    assign bus.mem_req = r_mem_req && rdy;
    assign bus.mem_a   = r_mem_a;
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected words, arrival cycles
// and byte addresses; monitors pop and compare as the DUT presents them.
module tb_icache;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    icache_if bus ();

    icache #(.IDX_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram [0:4095];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_word_q [$];
    int          exp_cyc_q  [$];
    logic [31:0] exp_addr_q [$];
    bit          gq [$];
    logic        prev_flg = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arbiter data path: the byte of the granted address appears next cycle.
    always @(posedge clk) begin
        if (rst) bus.mem_din <= 8'h00;
        else if (bus.mem_req && bus.mem_gnt) bus.mem_din <= ram[bus.mem_a[11:0]];
    end

    // Grant driver: replays a queued pattern while requested, else grants.
    always @(negedge clk) begin
        #1;
        if (bus.mem_req && rdy) begin
            if (gq.size() > 0) bus.mem_gnt = gq.pop_front();
            else bus.mem_gnt = 1'b1;
        end else begin
            bus.mem_gnt = 1'b0;
        end
    end

    // Grant monitor: every accepted byte address must match the expected order.
    always @(negedge clk) begin
        #2;
        if (bus.mem_req && bus.mem_gnt) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: mem_a=0x%08h granted, no byte read expected", bus.mem_a);
            end else begin
                check("mem_a", bus.mem_a, exp_addr_q.pop_front());
            end
        end
    end

    // Response monitor.
    always @(posedge clk) begin
        #1;
        if (bus.flg_get) begin
            $display("txn cycle=%0d ins_in=0x%08h", cyc, bus.ins_in);
            check("flg_single_pulse", {31'd0, prev_flg}, 32'd0);
            if (exp_word_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_flg: flg_get=1 ins_in=0x%08h, expected no response", bus.ins_in);
            end else begin
                check("ins_in", bus.ins_in, exp_word_q.pop_front());
                check("flg_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
        prev_flg = bus.flg_get;
    end

    task automatic issue(input logic [31:0] pc, input int lat, input logic [31:0] word,
                         input int nb, input int hold);
        logic [31:0] base;
        base = {pc[31:2], 2'b00};
        @(negedge clk);
        if (lat >= 0) begin
            exp_word_q.push_back(word);
            exp_cyc_q.push_back(cyc + 1 + lat);
        end
        for (int k = 0; k < nb; k++) exp_addr_q.push_back(base + k);
        bus.nd_ins   = 1'b1;
        bus.pc_fetch = pc;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.nd_ins   = 1'b0;
        bus.pc_fetch = 32'hFFFF_FFF0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_word_q.size() > 0 || exp_addr_q.size() > 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: %0d responses and %0d byte reads still outstanding",
                     exp_word_q.size(), exp_addr_q.size());
            exp_word_q.delete();
            exp_cyc_q.delete();
            exp_addr_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'hAA;
        ram[12'h000] = 8'h13; ram[12'h001] = 8'h05; ram[12'h002] = 8'h00; ram[12'h003] = 8'h00;
        ram[12'h004] = 8'hEF; ram[12'h005] = 8'hBE; ram[12'h006] = 8'hAD; ram[12'h007] = 8'hDE;
        ram[12'h010] = 8'h37; ram[12'h011] = 8'h12; ram[12'h012] = 8'h00; ram[12'h013] = 8'h00;
        ram[12'h020] = 8'h01; ram[12'h021] = 8'h02; ram[12'h022] = 8'h03; ram[12'h023] = 8'h04;
        ram[12'h030] = 8'h78; ram[12'h031] = 8'h56; ram[12'h032] = 8'h34; ram[12'h033] = 8'h12;
        ram[12'h400] = 8'h93; ram[12'h401] = 8'h00; ram[12'h402] = 8'h10; ram[12'h403] = 8'h00;

        rst = 1'b1;
        rdy = 1'b1;
        bus.jal_reset = 1'b0;
        bus.nd_ins    = 1'b0;
        bus.pc_fetch  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flg_get", {31'd0, bus.flg_get}, 32'd0);
        check("rst_ins_in", bus.ins_in, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_a", bus.mem_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, then hit with nd_ins held through the DONE cycle.
        issue(32'h0, 5, 32'h0000_0513, 4, 1);
        wait_idle();
        issue(32'h0, 0, 32'h0000_0513, 0, 2);
        check("hit_mem_req_low", {31'd0, bus.mem_req}, 32'd0);
        wait_idle();

        // Conflict eviction on index 0.
        issue(32'h400, 5, 32'h0010_0093, 4, 1);
        wait_idle();
        issue(32'h0, 5, 32'h0000_0513, 4, 1);
        wait_idle();

        // Grant gaps: captures at +2,+5,+6,+8.
        gq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        issue(32'h20, 8, 32'h0403_0201, 4, 1);
        wait_idle();

        // Flush after two grants; a third grant lands on the abort edge.
        issue(32'h10, -1, 32'h0, 3, 1);
        @(negedge clk);
        @(negedge clk);
        bus.jal_reset = 1'b1;
        @(posedge clk);
        #1;
        check("flush_mem_req_low", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        bus.jal_reset = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        issue(32'h10, 5, 32'h0000_1237, 4, 1);
        wait_idle();

        // rdy low for three edges after two grants.
        issue(32'h30, 8, 32'h1234_5678, 4, 1);
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        @(posedge clk);
        #1;
        check("freeze_mem_req_low", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b1;
        wait_idle();

        // Misaligned pc returns the enclosing word.
        issue(32'h6, 5, 32'hDEAD_BEEF, 4, 1);
        wait_idle();

        // Reset mid-miss invalidates every line.
        issue(32'h40, -1, 32'h0, 2, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_flg_get", {31'd0, bus.flg_get}, 32'd0);
        check("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_idle();
        issue(32'h4, 5, 32'hDEAD_BEEF, 4, 1);
        wait_idle();
        issue(32'h0, 5, 32'h0000_0513, 4, 1);
        wait_idle();

        check("outstanding_responses", exp_word_q.size(), 32'd0);
        check("outstanding_reads", exp_addr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
